mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit for the single-cycle MIPS datapath, directly downstream of the register file. It consumes the two register-file read operands (Rs, Rt) for MULT/MULTU/DIV/DIVU and produces the architectural HI/LO pair. HI/LO are later read back through the register-file write port by MFHI/MFLO, and written directly by MTHI/MTLO. Each operation takes a fixed 34 cycles, with a busy/done handshake toward control.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- RsData  in  WIDTH  operand A (multiplicand / dividend); sampled with start.
- RtData  in  WIDTH  operand B (multiplier / divisor); sampled with start.
- HiWrite  in  1  MTHI strobe.
- LoWrite  in  1  MTLO strobe.
- WrData  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- Reset values: busy=0, done=0, Hi=0, Lo=0, FSM=IDLE, iteration counter=0.
- FSM: IDLE -> CALC on start; CALC -> FIX after WIDTH iterations; FIX -> IDLE unconditionally.
- Capture on start edge:
  - Signed ops (MULT, DIV) latch |RsData| and |RtData|, plus result-sign and remainder-sign flags.
  - Unsigned ops latch the operands raw.
- CALC does one bit per cycle:
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
- FIX stage:
  - Applies sign correction: product and quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Writes Hi/Lo. Multiply: Hi = upper half, Lo = lower half. Divide: Lo = quotient, Hi = remainder.
- Divide by zero (DIV or DIVU): Lo=0xFFFFFFFF, Hi=RsData as captured. FIX forces these values regardless of signedness.
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0 (truncated magnitude result; no trap).
- start while busy: ignored; no queuing.
- HiWrite/LoWrite while busy: ignored.
- HiWrite/LoWrite in IDLE: the register is written on that edge.
- start and HiWrite/LoWrite in the same IDLE cycle: both take effect; the completion write overwrites the moved value.
- HiWrite and LoWrite together: both registers written.
- rst asserted in any state, including mid-CALC: immediate return to reset values; the in-flight result is discarded and no done is produced.

## Timing
- Edge 0: start accepted in IDLE; operands captured; busy=1 from after edge 0.
- Edges 1..WIDTH: iterations 0..WIDTH-1; counter wraps to 0 on the last iteration, then FSM=FIX.
- Edge WIDTH+1 (33): Hi/Lo written; done=1 and busy=0 for exactly the following cycle; FSM=IDLE.
- Back-to-back: a new start may be asserted during the done cycle and is accepted on that edge.
- Total latency: 34 cycles, start edge to Hi/Lo valid.
- Outputs are registered; there is no combinational path from inputs to Hi/Lo/busy/done.

## Structure
- Shared package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - FSM state enum: IDLE, CALC, FIX;
  - MDU_ITER = 32.
- One combinational sub-module, mul_div_step, implements a single iteration:
  - inputs: accumulator/remainder, operand, op class;
  - outputs: next accumulator/remainder and quotient bit.
- The top level keeps the FSM, the counter, sign handling and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; done pulses exactly 34 cycles after start; busy high for 33 cycles.
- MULT 0xFFFFFFFD × 0x00000007 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0.
- DIV 0xFFFFFFF9 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7 / 2 -> Lo=3, Hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=5.
- Handshake and moves:
  - start again at cycle 5 of a MULTU 3×4, and HiWrite 0xDEAD at cycle 6: both ignored; final Hi=0, Lo=12.
  - HiWrite 0x12345678 in IDLE: Hi=0x12345678 the next cycle.
- rst pulsed at cycle 10 of a DIVU: busy=0, Hi=Lo=0 the next cycle; no done pulse; a following MULTU 2×3 completes normally with Lo=6.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

   localparam int unsigned MDU_ITER = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module mul_div_step
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_ITER
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic               is_div_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               q_bit_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      acc_o   = acc_i;
      q_bit_o = 1'b0;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (is_div_i) begin
         // acc = {remainder, dividend bits}; quotient bits enter at the LSB
         shifted = acc_i[2*WIDTH-1:WIDTH-1];
         diff    = shifted - {1'b0, operand_i};
         if (!diff[WIDTH]) begin
            acc_o   = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            q_bit_o = 1'b1;
         end else begin
            acc_o   = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         // acc = {partial product, remaining multiplier bits}
         if (acc_i[0]) begin
            sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
         end else begin
            sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
         end
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_ITER
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] RsData,
   input  logic [WIDTH-1:0] RtData,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WrData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int unsigned AW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] rs_q, rs_d;
   logic             is_div_q, is_div_d;
   logic             res_neg_q, res_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             op_is_div, op_signed;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [AW-1:0]    step_acc;
   logic             step_q;

   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag     = (op_signed && RsData[WIDTH-1]) ? WIDTH'(-RsData) : RsData;
   assign b_mag     = (op_signed && RtData[WIDTH-1]) ? WIDTH'(-RtData) : RtData;

   mul_div_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .is_div_i  (is_div_q),
      .acc_o     (step_acc),
      .q_bit_o   (step_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      rs_d      = rs_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (HiWrite) hi_d = WrData;
            if (LoWrite) lo_d = WrData;
            if (start) begin
               state_d   = CALC;
               busy_d    = 1'b1;
               cnt_d     = '0;
               is_div_d  = op_is_div;
               res_neg_d = op_signed & (RsData[WIDTH-1] ^ RtData[WIDTH-1]);
               rem_neg_d = op_signed & RsData[WIDTH-1];
               dbz_d     = (RtData == '0);
               rs_d      = RsData;
               if (op_is_div) begin
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
            end
         end
         CALC: begin
            acc_d = step_acc | AW'(step_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Divide by zero overrides the iterative result entirely
            if (is_div_q && dbz_q) begin
               lo_d = '1;
               hi_d = rs_q;
            end else if (is_div_q) begin
               lo_d = res_neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
               hi_d = rem_neg_q ? WIDTH'(-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
            end else begin
               lo_d = res_neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
               hi_d = res_neg_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(acc_q[WIDTH-1:0] == '0))
                                : acc_q[AW-1:WIDTH];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         rs_q      <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         rs_q      <= rs_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule
